// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID pipeline register slice:
// register-field positions, counter width and the stage bundle.
package if_id_stage_pkg;

  localparam logic [4:0] XZR = 5'd31;
  localparam int RN_LSB = 5;
  localparam int RM_LSB = 16;
  localparam int RT_LSB = 0;
  localparam int COUNTER_W = 16;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  function automatic logic [4:0] reg_field(
    input logic [31:0] instr,
    input int          lsb
  );
    return instr[lsb +: 5];
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-side inputs, ID/EX hazard inputs and IF/ID outputs
// bundled for the if_id_stage slice.
interface if_id_stage_if;
  import if_id_stage_pkg::*;

  logic [63:0]          PC_in;
  logic [31:0]          instruction_in;
  logic                 imem_valid;
  logic                 flush;
  logic                 ID_EX_MemRead;
  logic [4:0]           ID_EX_write_register;
  logic [63:0]          PC_out;
  logic [31:0]          instruction_out;
  logic                 valid_out;
  logic [4:0]           rn_out;
  logic [4:0]           rm_out;
  logic [4:0]           rt_out;
  logic                 PC_write;
  logic                 bubble;
  logic [COUNTER_W-1:0] stall_count;
  logic [COUNTER_W-1:0] flush_count;

  modport master (
    output PC_in, instruction_in, imem_valid, flush,
    output ID_EX_MemRead, ID_EX_write_register,
    input  PC_out, instruction_out, valid_out,
    input  rn_out, rm_out, rt_out,
    input  PC_write, bubble, stall_count, flush_count
  );

  modport slave (
    input  PC_in, instruction_in, imem_valid, flush,
    input  ID_EX_MemRead, ID_EX_write_register,
    output PC_out, instruction_out, valid_out,
    output rn_out, rm_out, rt_out,
    output PC_write, bubble, stall_count, flush_count
  );

endinterface

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard compare between the IF/ID source fields
// and the load destination held in ID/EX.
module hazard_detect
  import if_id_stage_pkg::*;
(
  input  logic       valid_i,
  input  logic       mem_read_i,
  input  logic [4:0] write_register_i,
  input  logic [4:0] rn_i,
  input  logic [4:0] rm_i,
  input  logic [4:0] rt_i,
  output logic       load_use_o
);

  logic hit;

  assign hit = (write_register_i == rn_i)
             | (write_register_i == rm_i)
             | (write_register_i == rt_i);

  // XZR reads as zero, so a load targeting it never forwards
  assign load_use_o = valid_i & mem_read_i
                    & (write_register_i != XZR) & hit;

endmodule

// File: rtl/if_id_stage_sat_counter.sv
// Saturating up-counter used for the stall/flush statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, branch flush
// and saturating stall/flush counters.
module if_id_stage
  import if_id_stage_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  if_id_stage_if.slave bus
);

  if_id_t     q;
  if_id_t     d;
  logic       load_use;
  logic [4:0] rn;
  logic [4:0] rm;
  logic [4:0] rt;

  assign rn = reg_field(q.instr, RN_LSB);
  assign rm = reg_field(q.instr, RM_LSB);
  assign rt = reg_field(q.instr, RT_LSB);

  hazard_detect u_hazard (
    .valid_i          (q.valid),
    .mem_read_i       (bus.ID_EX_MemRead),
    .write_register_i (bus.ID_EX_write_register),
    .rn_i             (rn),
    .rm_i             (rm),
    .rt_i             (rt),
    .load_use_o       (load_use)
  );

  // flush and load_use may overlap, hence priority
  always_comb begin
    d = q;
    priority case (1'b1)
      bus.flush: d = '0;
      load_use:  d = q;
      bus.imem_valid: begin
        d.pc    = bus.PC_in;
        d.instr = bus.instruction_in;
        d.valid = 1'b1;
      end
      default: begin
        d.instr = '0;
        d.valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= d;
  end

  sat_counter #(.W(COUNTER_W)) u_stall_cnt (
    .clk     (clock),
    .rst_n   (reset),
    .inc_i   (~bus.flush & load_use),
    .count_o (bus.stall_count)
  );

  sat_counter #(.W(COUNTER_W)) u_flush_cnt (
    .clk     (clock),
    .rst_n   (reset),
    .inc_i   (bus.flush & q.valid),
    .count_o (bus.flush_count)
  );

  assign bus.PC_out          = q.pc;
  assign bus.instruction_out = q.instr;
  assign bus.valid_out       = q.valid;
  assign bus.rn_out          = rn;
  assign bus.rm_out          = rm;
  assign bus.rt_out          = rt;
  assign bus.PC_write = reset
                      & (bus.flush | (bus.imem_valid & ~load_use));
  assign bus.bubble   = ~reset | load_use | ~q.valid;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed checks for if_id_stage: capture, load-use stall,
// XZR, flush priority, fetch gaps, saturation, async reset.
module tb_if_id_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  if_id_stage_if bus ();

  if_id_stage dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [63:0] pc,
    input logic [31:0] ins,
    input logic        iv,
    input logic        fl,
    input logic        mr,
    input logic [4:0]  wr
  );
    bus.PC_in                = pc;
    bus.instruction_in       = ins;
    bus.imem_valid           = iv;
    bus.flush                = fl;
    bus.ID_EX_MemRead        = mr;
    bus.ID_EX_write_register = wr;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(64'h100, 32'hF8400149, 1'b1, 1'b1, 1'b0, 5'd0);
    #2;
    chk("rst_pc",     bus.PC_out, 64'h0);
    chk("rst_valid",  bus.valid_out, 64'h0);
    chk("rst_pcw",    bus.PC_write, 64'h0);
    chk("rst_bubble", bus.bubble, 64'h1);
    chk("rst_stall",  bus.stall_count, 64'h0);
    chk("rst_flush",  bus.flush_count, 64'h0);

    tick();
    chk("rst_hold_valid", bus.valid_out, 64'h0);
    bus.flush = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    chk("pcw_after_rst", bus.PC_write, 64'h1);

    tick();
    chk("cap_pc",    bus.PC_out, 64'h100);
    chk("cap_valid", bus.valid_out, 64'h1);
    chk("cap_ins",   bus.instruction_out, 64'hF8400149);
    chk("cap_rn",    bus.rn_out, 64'd10);
    chk("cap_rt",    bus.rt_out, 64'd9);
    chk("cap_rm",    bus.rm_out, 64'd0);
    chk("cap_bubble", bus.bubble, 64'h0);

    drive(64'h104, 32'hF840017F, 1'b1, 1'b0, 1'b1, 5'd10);
    #1;
    chk("lu_pcw",    bus.PC_write, 64'h0);
    chk("lu_bubble", bus.bubble, 64'h1);
    tick();
    chk("lu_hold_pc",  bus.PC_out, 64'h100);
    chk("lu_hold_ins", bus.instruction_out, 64'hF8400149);
    chk("lu_hold_v",   bus.valid_out, 64'h1);
    chk("lu_stall1",   bus.stall_count, 64'h1);
    bus.ID_EX_MemRead = 1'b0;
    #1;
    chk("resume_pcw", bus.PC_write, 64'h1);
    tick();
    chk("resume_pc",  bus.PC_out, 64'h104);
    chk("resume_rn",  bus.rn_out, 64'd11);
    chk("resume_rt",  bus.rt_out, 64'd31);
    chk("resume_stall", bus.stall_count, 64'h1);

    drive(64'h108, 32'h8B020020, 1'b1, 1'b0, 1'b1, 5'd31);
    #1;
    chk("xzr_pcw",    bus.PC_write, 64'h1);
    chk("xzr_bubble", bus.bubble, 64'h0);
    tick();
    chk("xzr_pc",    bus.PC_out, 64'h108);
    chk("xzr_stall", bus.stall_count, 64'h1);
    chk("xzr_rm",    bus.rm_out, 64'd2);
    chk("xzr_rn",    bus.rn_out, 64'd1);

    drive(64'h10C, 32'hF8400149, 1'b1, 1'b1, 1'b1, 5'd2);
    #1;
    chk("fl_lu_bubble", bus.bubble, 64'h1);
    chk("fl_pcw",       bus.PC_write, 64'h1);
    tick();
    chk("fl_valid", bus.valid_out, 64'h0);
    chk("fl_ins",   bus.instruction_out, 64'h0);
    chk("fl_pc",    bus.PC_out, 64'h0);
    chk("fl_cnt",   bus.flush_count, 64'h1);
    chk("fl_stall", bus.stall_count, 64'h1);
    tick();
    chk("fl_idle_cnt", bus.flush_count, 64'h1);

    drive(64'h200, 32'h8B020020, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    chk("gap_load_pc", bus.PC_out, 64'h200);
    bus.imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_valid",  bus.valid_out, 64'h0);
      chk("gap_ins",    bus.instruction_out, 64'h0);
      chk("gap_pc",     bus.PC_out, 64'h200);
      chk("gap_pcw",    bus.PC_write, 64'h0);
      chk("gap_bubble", bus.bubble, 64'h1);
    end

    drive(64'h300, 32'hF8400149, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    chk("sat_load_pc", bus.PC_out, 64'h300);
    drive(64'h304, 32'h8B020020, 1'b1, 1'b0, 1'b1, 5'd10);
    for (int i = 0; i < 65533; i++) tick();
    chk("sat_near", bus.stall_count, 64'hFFFE);
    tick();
    chk("sat_top", bus.stall_count, 64'hFFFF);
    for (int i = 0; i < 2; i++) tick();
    chk("sat_hold", bus.stall_count, 64'hFFFF);
    chk("sat_pc",   bus.PC_out, 64'h300);

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", bus.stall_count, 64'h0);
    chk("arst_flush", bus.flush_count, 64'h0);
    chk("arst_pc",    bus.PC_out, 64'h0);
    chk("arst_valid", bus.valid_out, 64'h0);
    chk("arst_pcw",   bus.PC_write, 64'h0);
    chk("arst_bubble", bus.bubble, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
